// File: rtl/sd_spi_pkg.sv
// Shared types and SD-card protocol constants for the SPI master.
package sd_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } spi_state_t;

    localparam logic [7:0] SD_IDLE_BYTE   = 8'hFF;
    localparam logic [7:0] SD_START_TOKEN = 8'hFE;
    localparam logic [7:0] SD_R1_IDLE     = 8'h01;

    localparam logic [2:0] LAST_BIT = 3'd7;

endpackage

// File: rtl/sd_spi_master_if.sv
// Byte handshake plus SPI pins between the SD SPI master and its surroundings.
interface sd_spi_master_if;

    logic       cs_req;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       sck;
    logic       mosi;
    logic       miso;
    logic       ss_n;

    modport master (
        input  cs_req, tx_data, tx_valid, miso,
        output tx_ready, rx_data, rx_valid, busy, sck, mosi, ss_n
    );

    modport slave (
        output cs_req, tx_data, tx_valid, miso,
        input  tx_ready, rx_data, rx_valid, busy, sck, mosi, ss_n
    );

endinterface

// File: rtl/sd_spi_clkgen.sv
// Half-period counter: strobes once every CLK_DIV ce-qualified cycles while run is high.
module sd_spi_clkgen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic ce,
    input  logic run,
    output logic half_stb
);

    localparam logic [7:0] LAST_CNT = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;

    assign half_stb = run && ce && (cnt_q == LAST_CNT);

    // Held at zero outside a transfer so every byte starts a fresh half-period.
    always_ff @(posedge clk_sys) begin
        if (!reset_n || !run) begin
            cnt_q <= 8'd0;
        end else if (ce) begin
            cnt_q <= half_stb ? 8'd0 : cnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/sd_spi_master.sv
// SPI mode-0 byte master for an SD card: MSB first, idle line high, registered miso sampling.
module sd_spi_master
    import sd_spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    input  logic            ce,
    sd_spi_master_if.master bus
);

    spi_state_t state_q, state_d;
    logic [2:0] bit_cnt_q;
    logic [7:0] tx_shift_q;
    logic [7:0] rx_shift_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       ss_n_q;
    logic       miso_p1;
    logic       run;
    logic       half_stb;
    logic       tx_ready;
    logic       accept;
    logic       sck_rise;
    logic       next_bit;

    assign run = (state_q == ST_LOW) || (state_q == ST_HIGH);

    sd_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .ce       (ce),
        .run      (run),
        .half_stb (half_stb)
    );

    assign tx_ready = (state_q == ST_IDLE) && !ss_n_q && bus.cs_req;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        sck_rise = 1'b0;
        next_bit = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.tx_valid && tx_ready) begin
                accept  = 1'b1;
                state_d = ST_LOW;
            end
            ST_LOW: if (half_stb) begin
                sck_rise = 1'b1;
                state_d  = ST_HIGH;
            end
            ST_HIGH: if (half_stb) begin
                if (bit_cnt_q != LAST_BIT) begin
                    next_bit = 1'b1;
                    state_d  = ST_LOW;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control: bit counter, select line, receive strobe.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            bit_cnt_q  <= 3'd0;
            ss_n_q     <= 1'b1;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
        end else begin
            rx_valid_q <= 1'b0;
            if (state_q == ST_IDLE) ss_n_q <= ~bus.cs_req;
            if (accept)             bit_cnt_q <= 3'd0;
            else if (next_bit)      bit_cnt_q <= bit_cnt_q + 3'd1;
            if (state_q == ST_DONE) begin
                rx_valid_q <= 1'b1;
                rx_data_q  <= rx_shift_q;
            end
        end
    end

    // Stage p1: miso registered once, then shifted in on the rising-sck cycle.
    always_ff @(posedge clk_sys) begin
        miso_p1 <= bus.miso;
        if (accept)        tx_shift_q <= bus.tx_data;
        else if (next_bit) tx_shift_q <= {tx_shift_q[6:0], 1'b0};
        if (sck_rise)      rx_shift_q <= {rx_shift_q[6:0], miso_p1};
    end

    assign bus.tx_ready = tx_ready;
    assign bus.sck      = (state_q == ST_HIGH);
    assign bus.mosi     = run ? tx_shift_q[7] : SD_IDLE_BYTE[7];
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.ss_n     = ss_n_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_sd_spi_master.sv
// Scenario bench for sd_spi_master with CLK_DIV=2; expected bytes are queued on accept.
module tb_sd_spi_master;
    import sd_spi_pkg::*;

    logic clk_sys = 1'b0;
    logic reset_n;
    logic ce;
    logic loopback;
    logic miso_const;
    bit   ce_div3 = 1'b0;

    sd_spi_master_if bus();
    assign bus.miso = loopback ? bus.mosi : miso_const;

    sd_spi_master #(.CLK_DIV(2)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .ce      (ce),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int sck_rises = 0;
    logic sck_prev = 1'b0;
    logic [7:0] mosi_rec = 8'h00;
    logic [7:0] exp_q[$];

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (bus.sck && !sck_prev) begin
            sck_rises <= sck_rises + 1;
            mosi_rec  <= {mosi_rec[6:0], bus.mosi};
        end
        sck_prev <= bus.sck;
    end

    initial begin
        int ph = 0;
        ce = 1'b1;
        forever begin
            @(negedge clk_sys);
            ph = ph + 1;
            ce = ce_div3 ? (ph % 3 == 0) : 1'b1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] d, output int acc_edge);
        int n = 0;
        acc_edge = -1;
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        while (acc_edge < 0 && n < 100) begin
            if (bus.tx_ready) begin
                acc_edge = cyc + 1;
                exp_q.push_back(loopback ? d : {8{miso_const}});
            end
            @(negedge clk_sys);
            n++;
        end
        bus.tx_valid = 1'b0;
        checks++;
        if (acc_edge < 0) begin
            errors++;
            $display("FAIL accept_timeout got=none required=accept within 100 cycles");
        end
    endtask

    task automatic wait_rx(input int bound, output int rx_edge);
        int n = 0;
        rx_edge = -1;
        while (rx_edge < 0 && n < bound) begin
            if (bus.rx_valid) rx_edge = cyc;
            else begin
                @(negedge clk_sys);
                n++;
            end
        end
        checks++;
        if (rx_edge < 0) begin
            errors++;
            $display("FAIL rx_timeout got=none required=rx_valid within %0d cycles", bound);
        end
    endtask

    task automatic test_reset();
        logic [6:0] got;
        logic [6:0] req;
        string names[7] = '{"tx_ready", "busy", "rx_valid", "ss_n", "mosi", "sck", "rx_data_nz"};
        reset_n = 1'b0;
        bus.cs_req = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data = 8'h00;
        loopback = 1'b1;
        miso_const = 1'b1;
        repeat (3) @(negedge clk_sys);
        got = {bus.rx_data != 8'h00, bus.sck, bus.mosi, bus.ss_n, bus.rx_valid, bus.busy, bus.tx_ready};
        req = 7'b0011000;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (got[i] !== req[i]) begin
                errors++;
                $display("FAIL reset_%s got=%b required=%b", names[i], got[i], req[i]);
            end
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic test_loopback();
        int acc, rx, base;
        logic [7:0] e;
        bus.cs_req = 1'b1;
        loopback = 1'b1;
        repeat (2) @(negedge clk_sys);
        checks++;
        if (bus.ss_n !== 1'b0 || bus.tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL select got=ss_n %b tx_ready %b required=0 1", bus.ss_n, bus.tx_ready);
        end
        base = sck_rises;
        send_byte(8'hA5, acc);
        wait_rx(60, rx);
        checks++;
        if (rx - acc !== 33) begin
            errors++;
            $display("FAIL loop_latency got=%0d required=33", rx - acc);
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (bus.rx_data !== e) begin
            errors++;
            $display("FAIL loop_data got=%h required=%h", bus.rx_data, e);
        end
        @(negedge clk_sys);
        checks++;
        if (bus.rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL rx_valid_width got=%b required=0", bus.rx_valid);
        end
        checks++;
        if (sck_rises - base !== 8) begin
            errors++;
            $display("FAIL sck_rises got=%0d required=8", sck_rises - base);
        end
        checks++;
        if (mosi_rec !== 8'hA5) begin
            errors++;
            $display("FAIL mosi_pattern got=%b required=10100101", mosi_rec);
        end
        checks++;
        if (bus.mosi !== 1'b1 || bus.sck !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_lines got=mosi %b sck %b busy %b required=1 0 0", bus.mosi, bus.sck, bus.busy);
        end
    endtask

    task automatic test_miso_high();
        int acc, rx;
        logic [7:0] e;
        loopback = 1'b0;
        miso_const = 1'b1;
        send_byte(8'h40, acc);
        checks++;
        if (bus.busy !== 1'b1 || bus.tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_during got=busy %b tx_ready %b required=1 0", bus.busy, bus.tx_ready);
        end
        wait_rx(60, rx);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (bus.rx_data !== e || e !== SD_IDLE_BYTE) begin
            errors++;
            $display("FAIL miso_high_data got=%h required=%h", bus.rx_data, SD_IDLE_BYTE);
        end
        @(negedge clk_sys);
        loopback = 1'b1;
    endtask

    task automatic test_back_to_back();
        int acc1 = -1, acc2 = -1, rx1 = -1, rx2 = -1, n = 0;
        bit ss_hi = 1'b0;
        logic [7:0] e;
        loopback = 1'b1;
        bus.tx_data = 8'hFF;
        bus.tx_valid = 1'b1;
        while (rx2 < 0 && n < 200) begin
            if (bus.ss_n !== 1'b0) ss_hi = 1'b1;
            if (bus.rx_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                checks++;
                if (bus.rx_data !== e) begin
                    errors++;
                    $display("FAIL b2b_data got=%h required=%h", bus.rx_data, e);
                end
                if (rx1 < 0) rx1 = cyc;
                else         rx2 = cyc;
            end
            if (bus.tx_valid && bus.tx_ready) begin
                if (acc1 < 0) begin
                    acc1 = cyc + 1;
                    exp_q.push_back(8'hFF);
                end else begin
                    acc2 = cyc + 1;
                    exp_q.push_back(8'h00);
                end
            end
            @(negedge clk_sys);
            n++;
            if (acc1 >= 0) bus.tx_data = 8'h00;
            if (acc2 >= 0) bus.tx_valid = 1'b0;
        end
        bus.tx_valid = 1'b0;
        checks++;
        if (rx2 < 0 || acc2 !== rx1 + 1) begin
            errors++;
            $display("FAIL b2b_second_accept got=%0d required=%0d", acc2, rx1 + 1);
        end
        checks++;
        if (acc2 - acc1 !== 34) begin
            errors++;
            $display("FAIL b2b_spacing got=%0d required=34", acc2 - acc1);
        end
        checks++;
        if (ss_hi !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ss_n got=deasserted required=held low");
        end
    endtask

    task automatic test_cs_drop();
        int acc, rx, base, n = 0;
        bit bad = 1'b0;
        logic [7:0] e;
        loopback = 1'b1;
        base = sck_rises;
        send_byte(8'hC3, acc);
        while (sck_rises - base < 3 && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        bus.cs_req = 1'b0;
        wait_rx(80, rx);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (bus.rx_data !== e) begin
            errors++;
            $display("FAIL csdrop_data got=%h required=%h", bus.rx_data, e);
        end
        checks++;
        if (bus.ss_n !== 1'b0) begin
            errors++;
            $display("FAIL csdrop_ss_n_at_done got=%b required=0", bus.ss_n);
        end
        @(negedge clk_sys);
        checks++;
        if (bus.ss_n !== 1'b1) begin
            errors++;
            $display("FAIL csdrop_ss_n_after got=%b required=1", bus.ss_n);
        end
        bus.tx_data = 8'h55;
        bus.tx_valid = 1'b1;
        repeat (40) begin
            @(negedge clk_sys);
            if (bus.tx_ready || bus.busy || bus.rx_valid) bad = 1'b1;
        end
        bus.tx_valid = 1'b0;
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL csdrop_ignored got=activity required=no transfer");
        end
    endtask

    task automatic test_reset_mid();
        int acc, base, n = 0;
        bit seen = 1'b0;
        bus.cs_req = 1'b1;
        repeat (2) @(negedge clk_sys);
        base = sck_rises;
        send_byte(8'h5A, acc);
        while (sck_rises - base < 5 && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        checks++;
        if (bus.sck !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_sck_high got=%b required=1", bus.sck);
        end
        reset_n = 1'b0;
        @(negedge clk_sys);
        checks++;
        if ({bus.sck, bus.ss_n, bus.busy, bus.rx_valid} !== 4'b0100) begin
            errors++;
            $display("FAIL rstmid_lines got=%b required=0100", {bus.sck, bus.ss_n, bus.busy, bus.rx_valid});
        end
        reset_n = 1'b1;
        exp_q.delete();
        repeat (80) begin
            @(negedge clk_sys);
            if (bus.rx_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_rx got=rx_valid required=none");
        end
    endtask

    task automatic test_ce_slow();
        int acc, rx;
        logic [7:0] e;
        loopback = 1'b1;
        ce_div3 = 1'b1;
        @(negedge clk_sys);
        send_byte(8'h3C, acc);
        wait_rx(400, rx);
        checks++;
        if (rx - acc < 95 || rx - acc > 99) begin
            errors++;
            $display("FAIL ce_latency got=%0d required=95..99", rx - acc);
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (bus.rx_data !== e) begin
            errors++;
            $display("FAIL ce_data got=%h required=%h", bus.rx_data, e);
        end
        ce_div3 = 1'b0;
        @(negedge clk_sys);
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_miso_high();
        test_back_to_back();
        test_cs_drop();
        test_reset_mid();
        test_ce_slow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sd_spi_master.md
SD_SPI_MASTER -- requirements
Module: sd_spi_master

Interface
REQ-001 CLK_DIV, default 2, SCK half-period in ce-qualified clk_sys cycles; legal range 1..255.
REQ-002 clk_sys  in  1  system clock; the only clock in the block.
REQ-003 reset_n  in  1  reset, synchronous to clk_sys, active-low.
REQ-004 ce  in  1  clock enable; all timing counters advance only when ce=1.
REQ-005 cs_req  in  1  level request to select the card; 1 selects.
REQ-006 tx_data  in  8  byte to send, MSB first.
REQ-007 tx_valid  in  1  tx_data is valid.
REQ-008 tx_ready  out  1  the block accepts tx_data in this cycle.
REQ-009 rx_data  out  8  byte received during the last transfer.
REQ-010 rx_valid  out  1  one-cycle strobe; rx_data is valid.
REQ-011 busy  out  1  a byte transfer is in progress.
REQ-012 sck  out  1  SPI clock, mode 0, idles low.
REQ-013 mosi  out  1  serial data out.
REQ-014 miso  in  1  serial data in; the sd_card responder drives it.
REQ-015 ss_n  out  1  card select, active-low.

Function
REQ-016 States are IDLE, LOW, HIGH and DONE; the block powers up in IDLE.
REQ-017 tx_ready = (state==IDLE) & ~ss_n & cs_req.
REQ-018 Transfer acceptance:
- a transfer is accepted on a clk_sys edge where tx_valid & tx_ready;
- ce is not required for acceptance;
- on acceptance, tx_data loads into the shift register, mosi = tx_data[7], bit count = 0, half-period counter = 0, state goes to LOW.
REQ-019 LOW: sck = 0; after CLK_DIV ce-cycles, sck rises, miso is sampled into rx_shift[0] with a left shift, state goes to HIGH.
REQ-020 HIGH: sck = 1; after CLK_DIV ce-cycles, sck falls.
- If bit count < 7: increment the count, mosi shows the next bit, state goes to LOW.
- Otherwise: state goes to DONE.
REQ-021 DONE lasts one clk_sys cycle, independent of ce:
- rx_data <= rx_shift;
- rx_valid = 1;
- mosi = 1;
- state goes to IDLE.
REQ-022 Latency: rx_valid asserts exactly 16*CLK_DIV ce-cycles plus 1 clk_sys cycle after the accept edge.
REQ-023 Back-to-back: if tx_valid is held, the next acceptance can occur in the cycle after DONE; the gap between transfers is at most 1 clk_sys cycle of sck low.
REQ-024 ss_n updates to ~cs_req only in IDLE.
- If cs_req falls mid-byte, the byte completes, then ss_n rises in the cycle after DONE.
REQ-025 busy = 1 in LOW, HIGH and DONE.
REQ-026 In IDLE, sck = 0 and mosi = 1 (SD idle line = 0xFF).
REQ-027 tx_valid while ss_n = 1 or while busy is ignored; no data is lost from the accepted byte.
REQ-028 miso is registered once before sampling; the sample is taken on the rising-sck cycle from that registered value.

Reset
REQ-029 When reset_n = 0 at a clk_sys edge, the outputs take these values:
- state = IDLE, sck = 0, mosi = 1, ss_n = 1;
- rx_data = 8'h00, rx_valid = 0, busy = 0;
- all counters = 0.
REQ-030 Reset mid-transfer aborts the transfer: no rx_valid is produced and sck returns low in the same edge.

Structure
REQ-031 Package sd_spi_pkg holds the state enum and the SD constants: SD_IDLE_BYTE = 8'hFF, SD_START_TOKEN = 8'hFE, SD_R1_IDLE = 8'h01.
REQ-032 Sub-module sd_spi_clkgen holds the half-period counter and produces a one-cycle edge strobe from ce and CLK_DIV.

Verification
REQ-033 Test conditions for every scenario: CLK_DIV = 2, ce = 1 unless a scenario states otherwise.
REQ-034 Loopback (miso tied to mosi), cs_req = 1, send 8'hA5: rx_valid at accept+33 cycles, rx_data = 8'hA5; 8 sck rising edges; mosi pattern 1,0,1,0,0,1,0,1.
REQ-035 miso held at 1, send 8'h40: rx_data = 8'hFF.
REQ-036 tx_valid held with 8'hFF then 8'h00: second accept in the cycle after the first DONE; ss_n stays 0 throughout.
REQ-037 cs_req dropped after 3 sck rises: byte completes with rx_valid; ss_n rises 1 cycle after DONE; a later tx_valid is not accepted.
REQ-038 reset_n pulsed low at the 5th sck rise: next edge shows sck = 0, ss_n = 1, busy = 0, and no rx_valid occurs.
REQ-039 ce asserted 1 in 3 cycles, send 8'h3C in loopback: rx_valid at 16*2*3 + 1 cycles after accept (±2 for ce phase), rx_data = 8'h3C.
